// File: rtl/uart_bus_master.sv
// Serial-to-bus initiator: receives 'W'/'R' command frames on RXD, performs
// one 32-bit bus access while holding the CPU off the bus, replies on TXD.
module uart_bus_master #(
  parameter int NRV_FREQ      = 50,
  parameter int NRV_BAUD_RATE = 115200,
  parameter int TIMEOUT_BITS  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RXD,
  output logic        TXD,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_rstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rbusy,
  input  logic        mem_wbusy,
  output logic        halt
);

  localparam int DIV_RAW = (NRV_FREQ * 1000000) / NRV_BAUD_RATE;
  localparam int DIV     = (DIV_RAW < 4) ? 4 : DIV_RAW;
  localparam int CNT_W   = $clog2(DIV);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);
  localparam logic [7:0] OP_W = 8'h57;
  localparam logic [7:0] OP_R = 8'h52;
  localparam logic [7:0] ACK  = 8'h4B;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_WR_STB, S_WR_WAIT, S_RD_STB, S_RD_WAIT, S_REPLY
  } state_t;

  rx_state_t rx_state, rx_next;
  state_t    state, next;

  logic             rx_s1, rx_s2, rx_prev;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_byte;
  logic             rx_vld, rx_ferr, rx_busy;

  logic [3:0]       tx_bits;
  logic [CNT_W-1:0] tx_cnt;
  logic [8:0]       tx_shift;
  logic             tx_ready, tx_load;

  logic [29:0]             addr;
  logic                    is_write;
  logic [1:0]              byte_cnt;
  logic [TIMEOUT_BITS-1:0] to_cnt;
  logic                    counting, timeout;
  logic [31:0]             reply_data;
  logic [2:0]              reply_left;

  assign rx_busy   = (rx_state != RX_IDLE);
  assign tx_ready  = (tx_bits == 4'd0) || (tx_bits == 4'd1 && tx_cnt == BIT_LAST);
  assign mem_addr  = {addr, 2'b00};
  assign mem_wmask = (state == S_WR_STB) ? 4'b1111 : 4'b0000;
  assign mem_rstrb = (state == S_RD_STB);
  assign halt      = (state != S_IDLE);
  assign counting  = (state == S_ADDR || state == S_DATA) && !rx_busy && !rx_vld;
  assign timeout   = &to_cnt;

  // Synchronise RXD and keep the previous sample for falling-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) {rx_s1, rx_s2, rx_prev} <= 3'b111;
    else       {rx_s1, rx_s2, rx_prev} <= {RXD, rx_s1, rx_s2};
  end

  // Receiver next state: start check at half bit, then 8 data bits and stop
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_s2) rx_next = RX_START;
      RX_START: if (rx_cnt == HALF_LAST) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_cnt == BIT_LAST && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_cnt == BIT_LAST) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // Receiver state, bit timing and the byte-valid / framing-error pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= 3'd0;
      rx_vld   <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_state <= rx_next;
      rx_vld   <= 1'b0;
      rx_ferr  <= 1'b0;
      if (rx_state == RX_IDLE || rx_next != rx_state || rx_cnt == BIT_LAST) rx_cnt <= '0;
      else rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == RX_START) rx_bit <= 3'd0;
      else if (rx_state == RX_DATA && rx_cnt == BIT_LAST) rx_bit <= rx_bit + 1'b1;
      if (rx_state == RX_STOP && rx_cnt == BIT_LAST) begin
        rx_vld  <= rx_s2;
        rx_ferr <= !rx_s2;
      end
    end
  end

  // Receive shift register, LSB arrives first
  always_ff @(posedge clk) begin
    if (rx_state == RX_DATA && rx_cnt == BIT_LAST) rx_byte <= {rx_s2, rx_byte[7:1]};
  end

  // Transmitter line and bit timing; a new byte may load on the last stop cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      TXD     <= 1'b1;
      tx_bits <= 4'd0;
      tx_cnt  <= '0;
    end else if (tx_load) begin
      TXD     <= 1'b0;
      tx_bits <= 4'd10;
      tx_cnt  <= '0;
    end else if (tx_bits != 4'd0) begin
      if (tx_cnt == BIT_LAST) begin
        tx_cnt  <= '0;
        tx_bits <= tx_bits - 4'd1;
        TXD     <= tx_shift[0];
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  // Bits still to send after the current one: data LSB first, then stop
  always_ff @(posedge clk) begin
    if (tx_load) tx_shift <= {1'b1, reply_data[7:0]};
    else if (tx_bits != 4'd0 && tx_cnt == BIT_LAST) tx_shift <= {1'b1, tx_shift[8:1]};
  end

  // Command state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next;
  end

  // Command sequencing: collect frame, one bus strobe, reply, back to idle
  always_comb begin
    next    = state;
    tx_load = 1'b0;
    case (state)
      S_IDLE:    if (rx_vld && (rx_byte == OP_W || rx_byte == OP_R)) next = S_ADDR;
      S_ADDR: begin
        if (rx_ferr || timeout) next = S_IDLE;
        else if (rx_vld && byte_cnt == 2'd3) next = is_write ? S_DATA : S_RD_STB;
      end
      S_DATA: begin
        if (rx_ferr || timeout) next = S_IDLE;
        else if (rx_vld && byte_cnt == 2'd3) next = S_WR_STB;
      end
      S_WR_STB:  next = S_WR_WAIT;
      S_WR_WAIT: if (!mem_wbusy) next = S_REPLY;
      S_RD_STB:  next = S_RD_WAIT;
      S_RD_WAIT: if (!mem_rbusy) next = S_REPLY;
      S_REPLY: begin
        if (reply_left != 3'd0) tx_load = tx_ready;
        else if (tx_bits == 4'd0) next = S_IDLE;
      end
      default:   next = S_IDLE;
    endcase
  end

  // Frame fields, byte counting, inter-byte idle timer and reply bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr       <= '0;
      mem_wdata  <= '0;
      is_write   <= 1'b0;
      byte_cnt   <= 2'd0;
      to_cnt     <= '0;
      reply_left <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          byte_cnt <= 2'd0;
          if (rx_vld) is_write <= (rx_byte == OP_W);
        end
        S_ADDR: if (rx_vld) begin
          addr     <= {rx_byte, addr[29:8]};
          byte_cnt <= byte_cnt + 2'd1;
        end
        S_DATA: if (rx_vld) begin
          mem_wdata <= {rx_byte, mem_wdata[31:8]};
          byte_cnt  <= byte_cnt + 2'd1;
        end
        S_WR_WAIT: if (!mem_wbusy) reply_left <= 3'd1;
        S_RD_WAIT: if (!mem_rbusy) reply_left <= 3'd4;
        S_REPLY:   if (tx_load) reply_left <= reply_left - 3'd1;
        default: ;
      endcase
      if (!counting)    to_cnt <= '0;
      else if (!timeout) to_cnt <= to_cnt + 1'b1;
    end
  end

  // Reply bytes, consumed least-significant byte first
  always_ff @(posedge clk) begin
    if (state == S_WR_WAIT && !mem_wbusy)      reply_data <= {24'h0, ACK};
    else if (state == S_RD_WAIT && !mem_rbusy) reply_data <= mem_rdata;
    else if (tx_load)                          reply_data <= {8'h00, reply_data[31:8]};
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Bench for uart_bus_master: frame-level model of expected bus accesses and
// reply bytes, checked against a serial decoder of TXD and the bus strobes.
`timescale 1ns/1ps
module tb_uart_bus_master;
  localparam int DIV = 8;

  logic        clk = 1'b0;
  logic        reset, RXD, TXD;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb, mem_rbusy, mem_wbusy, halt;

  always #5 clk = ~clk;

  uart_bus_master #(.NRV_FREQ(1), .NRV_BAUD_RATE(125000), .TIMEOUT_BITS(6)) dut (
    .clk(clk), .reset(reset), .RXD(RXD), .TXD(TXD),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata), .mem_rbusy(mem_rbusy),
    .mem_wbusy(mem_wbusy), .halt(halt)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct { bit is_w; logic [31:0] addr; logic [31:0] data; } bus_op_t;
  bus_op_t     exp_bus[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  tx_log[$];
  logic [31:0] rd_value = 32'h0;
  logic [31:0] last_wr_addr = 32'hx, last_wr_data = 32'hx, last_rd_addr = 32'hx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Model: a complete frame produces one bus access and a known reply
  task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
    exp_bus.push_back('{1'b1, a & 32'hFFFF_FFFC, d});
    exp_tx.push_back(8'h4B);
  endtask

  task automatic expect_read(input logic [31:0] a, input logic [31:0] v);
    rd_value = v;
    exp_bus.push_back('{1'b0, a & 32'hFFFF_FFFC, 32'h0});
    for (int i = 0; i < 4; i++) exp_tx.push_back(8'((v >> (8 * i)) & 32'hFF));
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    RXD = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      repeat (DIV) @(negedge clk);
    end
    RXD = stop_bit;
    repeat (DIV) @(negedge clk);
    RXD = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(8'((w >> (8 * i)) & 32'hFF), 1'b1);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 1500; i++) begin
      if (!halt) break;
      @(negedge clk);
    end
    chk({name, "_halt_fall"}, {31'b0, halt}, 32'd0);
    chk({name, "_bus_left"}, exp_bus.size(), 32'd0);
    chk({name, "_tx_left"}, exp_tx.size(), 32'd0);
  endtask

  // Bus slave: read busy 3 cycles then data; write busy 2 cycles
  int rcnt = 0, wcnt = 0;
  initial begin
    mem_rbusy = 1'b0;
    mem_wbusy = 1'b0;
    mem_rdata = 32'hBAD0_BAD0;
    forever begin
      @(negedge clk);
      if (reset) begin
        rcnt = 0; wcnt = 0; mem_rbusy = 1'b0; mem_wbusy = 1'b0;
      end else begin
        if (mem_rstrb) begin
          rcnt = 3; mem_rbusy = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        end else if (rcnt > 0) begin
          rcnt--;
          if (rcnt == 0) begin mem_rbusy = 1'b0; mem_rdata = rd_value; end
        end
        if (mem_wmask != 4'h0) begin
          wcnt = 2; mem_wbusy = 1'b1;
        end else if (wcnt > 0) begin
          wcnt--;
          if (wcnt == 0) mem_wbusy = 1'b0;
        end
      end
    end
  end

  // Compare process: bus strobes against the model queue, TXD decoded serially
  bus_op_t    mon_op;
  bit         mon_busy = 1'b0;
  int         mon_cnt = 0;
  logic       mon_bitval;
  logic [7:0] mon_byte;
  always @(negedge clk) begin
    if (reset) begin
      mon_busy = 1'b0;
      exp_bus.delete();
      exp_tx.delete();
    end else begin
      if (mem_wmask != 4'h0 || mem_rstrb) begin
        if (exp_bus.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_strobe: wmask=%h rstrb=%b addr=%h, expected no access",
                   mem_wmask, mem_rstrb, mem_addr);
        end else begin
          mon_op = exp_bus.pop_front();
          chk("strobe_kind", {27'b0, mem_wmask, mem_rstrb}, mon_op.is_w ? 32'h1E : 32'h01);
          chk("strobe_addr", mem_addr, mon_op.addr);
          if (mon_op.is_w) begin
            chk("strobe_wdata", mem_wdata, mon_op.data);
            last_wr_addr = mem_addr;
            last_wr_data = mem_wdata;
          end else begin
            last_rd_addr = mem_addr;
          end
        end
      end
      if (!mon_busy && TXD == 1'b0) begin
        mon_busy = 1'b1;
        mon_cnt  = 0;
      end
      if (mon_busy) begin
        if (mon_cnt % DIV == 0) begin
          mon_bitval = TXD;
          if (mon_cnt / DIV >= 1 && mon_cnt / DIV <= 8) mon_byte[mon_cnt / DIV - 1] = TXD;
        end else if (mon_cnt % DIV == DIV - 1) begin
          chk("tx_bit_width", {31'b0, TXD}, {31'b0, mon_bitval});
        end
        if (mon_cnt == 10 * DIV - 1) begin
          chk("tx_stop_bit", {31'b0, mon_bitval}, 32'd1);
          if (exp_tx.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_tx: got byte %h, expected no byte", mon_byte);
          end else begin
            chk("tx_byte", {24'b0, mon_byte}, {24'b0, exp_tx.pop_front()});
          end
          tx_log.push_back(mon_byte);
          mon_busy = 1'b0;
        end
        mon_cnt++;
      end
    end
  end

  initial begin
    reset = 1'b1;
    RXD   = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_txd", {31'b0, TXD}, 32'd1);
    chk("rst_halt", {31'b0, halt}, 32'd0);
    chk("rst_wmask", {28'b0, mem_wmask}, 32'd0);
    chk("rst_rstrb", {31'b0, mem_rstrb}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    #2 reset = 1'b0;
    repeat (4) @(negedge clk);

    // Write word
    expect_write(32'h10, 32'hDEAD_BEEF);
    tx_log.delete();
    send_byte(8'h57, 1'b1);
    repeat (2) @(negedge clk);
    chk("wr_halt_rise", {31'b0, halt}, 32'd1);
    send_word(32'h10);
    send_word(32'hDEAD_BEEF);
    wait_done("wr");
    chk("wr_addr_lit", last_wr_addr, 32'h0000_0010);
    chk("wr_data_lit", last_wr_data, 32'hDEAD_BEEF);
    chk("wr_reply_lit", {24'b0, tx_log[0]}, 32'h4B);

    // Read word, unaligned address, slow slave
    expect_read(32'h13, 32'h1234_5678);
    tx_log.delete();
    send_byte(8'h52, 1'b1);
    send_word(32'h13);
    wait_done("rd");
    chk("rd_addr_lit", last_rd_addr, 32'h0000_0010);
    chk("rd_reply_cnt", tx_log.size(), 32'd4);
    chk("rd_reply_lit", {tx_log[3], tx_log[2], tx_log[1], tx_log[0]}, 32'h1234_5678);

    // Inter-byte timeout drops a partial write
    send_byte(8'h57, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    repeat (2) @(negedge clk);
    chk("to_halt_held", {31'b0, halt}, 32'd1);
    repeat (80) @(negedge clk);
    chk("to_halt_drop", {31'b0, halt}, 32'd0);
    expect_read(32'h20, 32'hCAFE_F00D);
    send_byte(8'h52, 1'b1);
    send_word(32'h20);
    wait_done("after_to");

    // Garbage opcodes ignored, framing error aborts a read frame
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    repeat (2) @(negedge clk);
    chk("garbage_idle", {31'b0, halt}, 32'd0);
    send_byte(8'h52, 1'b1);
    repeat (2) @(negedge clk);
    chk("fe_halt_rise", {31'b0, halt}, 32'd1);
    send_byte(8'h13, 1'b0);
    repeat (10) @(negedge clk);
    chk("fe_abort", {31'b0, halt}, 32'd0);
    chk("fe_txd_idle", {31'b0, TXD}, 32'd1);
    expect_read(32'h44, 32'h0BAD_F00D);
    send_byte(8'h52, 1'b1);
    send_word(32'h44);
    wait_done("after_fe");

    // Short low glitch mid-address is not a byte
    expect_read(32'h08, 32'h5A5A_0001);
    send_byte(8'h52, 1'b1);
    send_byte(8'h08, 1'b1);
    send_byte(8'h00, 1'b1);
    RXD = 1'b0;
    repeat (2) @(negedge clk);
    RXD = 1'b1;
    repeat (20) @(negedge clk);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_done("glitch");
    chk("glitch_addr_lit", last_rd_addr, 32'h0000_0008);

    // Reset during the read reply
    expect_read(32'h30, 32'h1122_3344);
    send_byte(8'h52, 1'b1);
    send_word(32'h30);
    for (int i = 0; i < 300; i++) begin
      if (TXD == 1'b0) break;
      @(negedge clk);
    end
    chk("reply_started", {31'b0, TXD}, 32'd0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_txd", {31'b0, TXD}, 32'd1);
    chk("async_rst_halt", {31'b0, halt}, 32'd0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_halt", {31'b0, halt}, 32'd0);
    chk("post_rst_txd", {31'b0, TXD}, 32'd1);
    expect_read(32'h7C, 32'h89AB_CDEF);
    tx_log.delete();
    send_byte(8'h52, 1'b1);
    send_word(32'h7C);
    wait_done("post_rst");
    chk("post_rst_reply_lit", {tx_log[3], tx_log[2], tx_log[1], tx_log[0]}, 32'h89AB_CDEF);

    repeat (20) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
